// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
//   Shared definitions for the register-file writeback scheduler.
//   REG_ADDR_W  : register address width (32 architectural registers).
//   WB_DATA_W   : default result width.
//   AGE_*       : age-order position of each result source within a cycle
//                 (alu0 oldest, mem youngest).
//   wb_entry_t  : one queued result (destination + data) at default width.
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_DATA_W  = 32;

  localparam int NUM_SRC  = 3;
  localparam int AGE_ALU0 = 0;
  localparam int AGE_ALU1 = 1;
  localparam int AGE_MEM  = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_queue.sv
// wb_entry_queue
//   3-push / 2-pop circular buffer of writeback entries.
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset (pointers/count only)
//     pushCnt       : number of entries written this cycle (0..3), taken from
//                     pushEntry[0..pushCnt-1] in order
//     pushEntry     : compacted push slots, oldest first
//     popCnt        : number of entries removed this cycle (0..2)
//     headEntry     : oldest entry
//     nextEntry     : second-oldest entry
//     headPtr       : storage index of the oldest entry
//     count         : occupancy
//     entries       : raw storage array (for associative lookup)
//   The caller guarantees no overflow (push only when count <= DEPTH-3) and
//   no underflow (popCnt <= count).
module wb_entry_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type entry_t = wb_entry_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pushCnt,
  input  entry_t           pushEntry [NUM_SRC],
  input  logic [1:0]       popCnt,
  output entry_t           headEntry,
  output entry_t           nextEntry,
  output logic [PTR_W-1:0] headPtr,
  output logic [CNT_W-1:0] count,
  output entry_t           entries [DEPTH]
);

  logic [PTR_W-1:0] tailPtr;
  entry_t           mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      headPtr <= headPtr + PTR_W'(popCnt);
      tailPtr <= tailPtr + PTR_W'(pushCnt);
      count   <= count + CNT_W'(pushCnt) - CNT_W'(popCnt);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i < int'(pushCnt)) begin
        mem[tailPtr + PTR_W'(i)] <= pushEntry[i];
      end
    end
  end

  assign headEntry = mem[headPtr];
  assign nextEntry = mem[headPtr + PTR_W'(1)];
  assign entries   = mem;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Collects completed results from ALU lane 0, ALU lane 1 and the load unit,
//   queues them in age order and drains up to two per cycle into the two
//   write ports of the 4-read/2-write register file. When both popped entries
//   target the same register only the younger one (port 2) writes.
//   Ports:
//     clk, rst                     : clock, asynchronous active-low reset
//     alu0*/alu1*/mem* Valid/Dest/Data : result inputs (alu0 oldest)
//     inReady                      : shared ready, high while count <= DEPTH-3
//     we1/we2, writeRegister1/2, writeData1/2 : registered write ports
//     pendingCount                 : queue occupancy
//     fwdReg/fwdHit/fwdData        : forwarding lookup (REGFILE_WB_FWD_EN only)
//   Build option: define REGFILE_WB_FWD_EN to add the forwarding lookup.
module regfile_wb_scheduler
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu0Valid,
  input  logic [REG_ADDR_W-1:0]   alu0Dest,
  input  logic [DATA_W-1:0]       alu0Data,
  input  logic                    alu1Valid,
  input  logic [REG_ADDR_W-1:0]   alu1Dest,
  input  logic [DATA_W-1:0]       alu1Data,
  input  logic                    memValid,
  input  logic [REG_ADDR_W-1:0]   memDest,
  input  logic [DATA_W-1:0]       memData,
  output logic                    inReady,
  output logic                    we1,
  output logic                    we2,
  output logic [REG_ADDR_W-1:0]   writeRegister1,
  output logic [REG_ADDR_W-1:0]   writeRegister2,
  output logic [DATA_W-1:0]       writeData1,
  output logic [DATA_W-1:0]       writeData2,
  output logic [$clog2(DEPTH):0]  pendingCount
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0]   fwdReg,
  output logic                    fwdHit,
  output logic [DATA_W-1:0]       fwdData
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } entry_t;

  entry_t             srcEntry [NUM_SRC];
  logic [NUM_SRC-1:0] srcVld;
  entry_t             pushEntry [NUM_SRC];
  logic [1:0]         pushCnt;
  logic [1:0]         popCnt;
  logic               pairConflict;
  entry_t             headEntry;
  entry_t             nextEntry;
  logic [PTR_W-1:0]   headPtr;
  logic [CNT_W-1:0]   count;
  entry_t             queueEntries [DEPTH];

  assign srcVld[AGE_ALU0]   = alu0Valid;
  assign srcVld[AGE_ALU1]   = alu1Valid;
  assign srcVld[AGE_MEM]    = memValid;
  assign srcEntry[AGE_ALU0] = '{dest: alu0Dest, data: alu0Data};
  assign srcEntry[AGE_ALU1] = '{dest: alu1Dest, data: alu1Data};
  assign srcEntry[AGE_MEM]  = '{dest: memDest,  data: memData};

  // ---- Stage p0: acceptance and push compaction ----
  // Ready looks only at registered occupancy, so at most 3 pushes can land
  // on a queue holding DEPTH-3 entries without overflowing.
  assign inReady = (count <= CNT_W'(DEPTH - 3));

  // Accepted results fill contiguous slots in age order; dest 0 is dropped.
  always_comb begin
    pushCnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pushEntry[i] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (srcVld[i] && inReady && (srcEntry[i].dest != '0)) begin
        pushEntry[pushCnt] = srcEntry[i];
        pushCnt            = pushCnt + 2'd1;
      end
    end
  end

  assign popCnt       = (count >= CNT_W'(2)) ? 2'd2 : {1'b0, count[0]};
  assign pairConflict = (count >= CNT_W'(2)) && (headEntry.dest == nextEntry.dest);

  wb_entry_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) uQueue (
    .clk       (clk),
    .rst       (rst),
    .pushCnt   (pushCnt),
    .pushEntry (pushEntry),
    .popCnt    (popCnt),
    .headEntry (headEntry),
    .nextEntry (nextEntry),
    .headPtr   (headPtr),
    .count     (count),
    .entries   (queueEntries)
  );

  // ---- Stage p1: registered write ports ----
  // Address/data registers load only when their entry pops; the enables
  // alone qualify the write, so held values are harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we1            <= 1'b0;
      we2            <= 1'b0;
      writeRegister1 <= '0;
      writeRegister2 <= '0;
      writeData1     <= '0;
      writeData2     <= '0;
    end else begin
      we1 <= (popCnt != 2'd0) && !pairConflict;
      we2 <= (popCnt == 2'd2);
      if (popCnt != 2'd0) begin
        writeRegister1 <= headEntry.dest;
        writeData1     <= headEntry.data;
      end
      if (popCnt == 2'd2) begin
        writeRegister2 <= nextEntry.dest;
        writeData2     <= nextEntry.data;
      end
    end
  end

  assign pendingCount = count;

`ifdef REGFILE_WB_FWD_EN
  // Later matches override earlier ones, so the scan order (port 1, port 2,
  // then queue oldest to youngest) yields youngest-wins priority.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    if (fwdReg != '0) begin
      if (we1 && (writeRegister1 == fwdReg)) begin
        fwdHit  = 1'b1;
        fwdData = writeData1;
      end
      if (we2 && (writeRegister2 == fwdReg)) begin
        fwdHit  = 1'b1;
        fwdData = writeData2;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((k < int'(count)) &&
            (queueEntries[headPtr + PTR_W'(k)].dest == fwdReg)) begin
          fwdHit  = 1'b1;
          fwdData = queueEntries[headPtr + PTR_W'(k)].data;
        end
      end
    end
  end
`else
  // Without forwarding the raw queue view has no consumer.
  logic [DEPTH-1:0] unusedEntryBits;
  logic             unusedFwd;
  for (genvar k = 0; k < DEPTH; k++) begin : gUnused
    assign unusedEntryBits[k] = ^queueEntries[k];
  end
  assign unusedFwd = ^{unusedEntryBits, headPtr};
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu0Valid, alu1Valid, memValid;
  logic [4:0]  alu0Dest, alu1Dest, memDest;
  logic [31:0] alu0Data, alu1Data, memData;
  logic        inReady, we1, we2;
  logic [4:0]  writeRegister1, writeRegister2;
  logic [31:0] writeData1, writeData2;
  logic [3:0]  pendingCount;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  fwdReg = '0;
  logic        fwdHit;
  logic [31:0] fwdData;
`endif

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu0Valid      (alu0Valid),
    .alu0Dest       (alu0Dest),
    .alu0Data       (alu0Data),
    .alu1Valid      (alu1Valid),
    .alu1Dest       (alu1Dest),
    .alu1Data       (alu1Data),
    .memValid       (memValid),
    .memDest        (memDest),
    .memData        (memData),
    .inReady        (inReady),
    .we1            (we1),
    .we2            (we2),
    .writeRegister1 (writeRegister1),
    .writeRegister2 (writeRegister2),
    .writeData1     (writeData1),
    .writeData2     (writeData2),
    .pendingCount   (pendingCount)
`ifdef REGFILE_WB_FWD_EN
    ,
    .fwdReg         (fwdReg),
    .fwdHit         (fwdHit),
    .fwdData        (fwdData)
`endif
  );

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  // Reference model: a plain in-order list of pending results plus the
  // expected state of the two write ports.
  ent_t        mq[$];
  logic        expWe1, expWe2;
  logic [4:0]  expWr1, expWr2;
  logic [31:0] expWd1, expWd2;
  logic [31:0] modelRf [32];
  logic [31:0] dutRf [32];

  int checks = 0;
  int errors = 0;

  task automatic modelReset();
    mq.delete();
    expWe1 = 1'b0;
    expWe2 = 1'b0;
    expWr1 = '0;
    expWr2 = '0;
    expWd1 = '0;
    expWd2 = '0;
  endtask

  task automatic idleInputs();
    alu0Valid = 1'b0; alu0Dest = '0; alu0Data = '0;
    alu1Valid = 1'b0; alu1Dest = '0; alu1Data = '0;
    memValid  = 1'b0; memDest  = '0; memData  = '0;
  endtask

  // Drives one cycle of inputs (called just after a falling edge), advances
  // the model across the rising edge and returns at the next falling edge.
  task automatic applyCycle(input logic v0, input logic [4:0] d0, input logic [31:0] x0,
                            input logic v1, input logic [4:0] d1, input logic [31:0] x1,
                            input logic v2, input logic [4:0] d2, input logic [31:0] x2);
    ent_t e1, e2;
    bit   rdy;
    alu0Valid = v0; alu0Dest = d0; alu0Data = x0;
    alu1Valid = v1; alu1Dest = d1; alu1Data = x1;
    memValid  = v2; memDest  = d2; memData  = x2;
    rdy    = (mq.size() <= DEPTH - 3);
    expWe1 = 1'b0;
    expWe2 = 1'b0;
    if (mq.size() >= 1) begin
      e1 = mq.pop_front();
      expWe1 = 1'b1; expWr1 = e1.dest; expWd1 = e1.data;
      if (mq.size() >= 1) begin
        e2 = mq.pop_front();
        expWe2 = 1'b1; expWr2 = e2.dest; expWd2 = e2.data;
        if (e2.dest == e1.dest) expWe1 = 1'b0;
      end
    end
    if (expWe1) modelRf[expWr1] = expWd1;
    if (expWe2) modelRf[expWr2] = expWd2;
    if (rdy) begin
      if (v0 && d0 != 0) mq.push_back('{d0, x0});
      if (v1 && d1 != 0) mq.push_back('{d1, x1});
      if (v2 && d2 != 0) mq.push_back('{d2, x2});
    end
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    if (we1) dutRf[writeRegister1] = writeData1;
    if (we2) dutRf[writeRegister2] = writeData2;
  endtask

  task automatic idleCycle();
    applyCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    idleInputs();
    modelReset();
    for (int r = 0; r < 32; r++) begin
      modelRf[r] = '0;
      dutRf[r]   = '0;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL reset_we1 got %b exp 0", we1); end
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL reset_we2 got %b exp 0", we2); end
    checks++; if (writeRegister1 !== 5'd0) begin errors++; $display("FAIL reset_wr1 got %0d exp 0", writeRegister1); end
    checks++; if (writeRegister2 !== 5'd0) begin errors++; $display("FAIL reset_wr2 got %0d exp 0", writeRegister2); end
    checks++; if (writeData1 !== 32'd0) begin errors++; $display("FAIL reset_wd1 got %h exp 0", writeData1); end
    checks++; if (writeData2 !== 32'd0) begin errors++; $display("FAIL reset_wd2 got %h exp 0", writeData2); end
    checks++; if (pendingCount !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", pendingCount); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b exp 1", inReady); end
`ifdef REGFILE_WB_FWD_EN
    fwdReg = 5'd5;
    #1;
    checks++; if (fwdHit !== 1'b0) begin errors++; $display("FAIL reset_fwdHit got %b exp 0", fwdHit); end
`endif
    rst = 1'b1;
  endtask

  task automatic test_single();
    applyCycle(1, 5'd5, 32'hAAAA_AAAA, 0, 0, 0, 0, 0, 0);
    checks++; if (pendingCount !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", pendingCount); end
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL single_early_we1 got %b exp 0", we1); end
    idleCycle();
    checks++; if (we1 !== 1'b1) begin errors++; $display("FAIL single_we1 got %b exp 1", we1); end
    checks++; if (writeRegister1 !== 5'd5) begin errors++; $display("FAIL single_wr1 got %0d exp 5", writeRegister1); end
    checks++; if (writeData1 !== 32'hAAAA_AAAA) begin errors++; $display("FAIL single_wd1 got %h exp aaaaaaaa", writeData1); end
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL single_we2 got %b exp 0", we2); end
    idleCycle();
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL single_we1_oneshot got %b exp 0", we1); end
  endtask

  task automatic test_pair();
    applyCycle(1, 5'd5, 32'h1111_1111, 1, 5'd10, 32'h5555_5555, 0, 0, 0);
    idleCycle();
    checks++; if ({we1, we2} !== 2'b11) begin errors++; $display("FAIL pair_we got %b exp 11", {we1, we2}); end
    checks++; if ({writeRegister1, writeData1} !== {5'd5, 32'h1111_1111}) begin
      errors++; $display("FAIL pair_port1 got %0d/%h exp 5/11111111", writeRegister1, writeData1); end
    checks++; if ({writeRegister2, writeData2} !== {5'd10, 32'h5555_5555}) begin
      errors++; $display("FAIL pair_port2 got %0d/%h exp 10/55555555", writeRegister2, writeData2); end
    idleCycle();
    checks++; if ({we1, we2} !== 2'b00) begin errors++; $display("FAIL pair_oneshot got %b exp 00", {we1, we2}); end
  endtask

  task automatic test_conflict();
    applyCycle(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 0, 0, 0);
    idleCycle();
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL conflict_we1 got %b exp 0", we1); end
    checks++; if (we2 !== 1'b1) begin errors++; $display("FAIL conflict_we2 got %b exp 1", we2); end
    checks++; if ({writeRegister2, writeData2} !== {5'd7, 32'h2}) begin
      errors++; $display("FAIL conflict_port2 got %0d/%h exp 7/2", writeRegister2, writeData2); end
    checks++; if (pendingCount !== 4'd0) begin errors++; $display("FAIL conflict_count got %0d exp 0", pendingCount); end
  endtask

  task automatic test_dest0();
    int maxCnt = 0;
    applyCycle(1, 5'd3, 32'h3333_0003, 0, 0, 0, 1, 5'd0, 32'hDEAD_0000);
    if (pendingCount > maxCnt) maxCnt = pendingCount;
    idleCycle();
    if (pendingCount > maxCnt) maxCnt = pendingCount;
    checks++; if (maxCnt !== 1) begin errors++; $display("FAIL dest0_count got %0d exp 1", maxCnt); end
    checks++; if ({we1, writeRegister1, writeData1} !== {1'b1, 5'd3, 32'h3333_0003}) begin
      errors++; $display("FAIL dest0_port1 got %b/%0d/%h exp 1/3/33330003", we1, writeRegister1, writeData1); end
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL dest0_we2 got %b exp 0", we2); end
  endtask

  task automatic test_burst();
    int maxCnt = 0;
    bit sawNotReady = 0;
    bit sawReadyAgain = 0;
    int badRegs = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 14)
        applyCycle(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom,
                   1, 5'($urandom_range(1, 31)), $urandom);
      else
        idleCycle();
      if (int'(pendingCount) > maxCnt) maxCnt = pendingCount;
      if (!inReady) sawNotReady = 1;
      if (sawNotReady && inReady && c < 14) sawReadyAgain = 1;
      checks++; if (pendingCount !== 4'(mq.size())) begin
        errors++; $display("FAIL burst_count c%0d got %0d exp %0d", c, pendingCount, mq.size()); end
      checks++; if (inReady !== (mq.size() <= DEPTH - 3)) begin
        errors++; $display("FAIL burst_inReady c%0d got %b exp %b", c, inReady, mq.size() <= DEPTH - 3); end
      checks++; if ({we1, we2} !== {expWe1, expWe2}) begin
        errors++; $display("FAIL burst_we c%0d got %b exp %b", c, {we1, we2}, {expWe1, expWe2}); end
      if (expWe1) begin
        checks++; if ({writeRegister1, writeData1} !== {expWr1, expWd1}) begin
          errors++; $display("FAIL burst_port1 c%0d got %0d/%h exp %0d/%h", c, writeRegister1, writeData1, expWr1, expWd1); end
      end
      if (expWe2) begin
        checks++; if ({writeRegister2, writeData2} !== {expWr2, expWd2}) begin
          errors++; $display("FAIL burst_port2 c%0d got %0d/%h exp %0d/%h", c, writeRegister2, writeData2, expWr2, expWd2); end
      end
    end
    checks++; if (maxCnt !== DEPTH - 2) begin errors++; $display("FAIL burst_maxcount got %0d exp %0d", maxCnt, DEPTH - 2); end
    checks++; if (!(sawNotReady && sawReadyAgain)) begin
      errors++; $display("FAIL burst_ready_cycle got %b%b exp 11", sawNotReady, sawReadyAgain); end
    for (int r = 0; r < 32; r++) if (dutRf[r] !== modelRf[r]) badRegs++;
    checks++; if (badRegs !== 0) begin errors++; $display("FAIL burst_regfile got %0d bad regs exp 0", badRegs); end
  endtask

  task automatic test_random();
    int badRegs = 0;
    for (int c = 0; c < 320; c++) begin
      if (c < 300)
        applyCycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
      else
        idleCycle();
      checks++; if (pendingCount !== 4'(mq.size())) begin
        errors++; $display("FAIL rand_count c%0d got %0d exp %0d", c, pendingCount, mq.size()); end
      checks++; if (inReady !== (mq.size() <= DEPTH - 3)) begin
        errors++; $display("FAIL rand_inReady c%0d got %b exp %b", c, inReady, mq.size() <= DEPTH - 3); end
      checks++; if ({we1, we2} !== {expWe1, expWe2}) begin
        errors++; $display("FAIL rand_we c%0d got %b exp %b", c, {we1, we2}, {expWe1, expWe2}); end
      if (expWe1) begin
        checks++; if ({writeRegister1, writeData1} !== {expWr1, expWd1}) begin
          errors++; $display("FAIL rand_port1 c%0d got %0d/%h exp %0d/%h", c, writeRegister1, writeData1, expWr1, expWd1); end
      end
      if (expWe2) begin
        checks++; if ({writeRegister2, writeData2} !== {expWr2, expWd2}) begin
          errors++; $display("FAIL rand_port2 c%0d got %0d/%h exp %0d/%h", c, writeRegister2, writeData2, expWr2, expWd2); end
      end
`ifdef REGFILE_WB_FWD_EN
      begin
        logic        eHit;
        logic [31:0] eData;
        fwdReg = 5'($urandom_range(0, 7));
        #1;
        eHit = 1'b0;
        eData = '0;
        if (fwdReg != 0) begin
          if (expWe1 && expWr1 == fwdReg) begin eHit = 1'b1; eData = expWd1; end
          if (expWe2 && expWr2 == fwdReg) begin eHit = 1'b1; eData = expWd2; end
          foreach (mq[k]) if (mq[k].dest == fwdReg) begin eHit = 1'b1; eData = mq[k].data; end
        end
        checks++; if (fwdHit !== eHit || (eHit && fwdData !== eData)) begin
          errors++; $display("FAIL rand_fwd c%0d reg %0d got %b/%h exp %b/%h", c, fwdReg, fwdHit, fwdData, eHit, eData); end
      end
`endif
    end
    for (int r = 0; r < 32; r++) if (dutRf[r] !== modelRf[r]) badRegs++;
    checks++; if (badRegs !== 0) begin errors++; $display("FAIL rand_regfile got %0d bad regs exp 0", badRegs); end
  endtask

  task automatic test_reset_mid();
    applyCycle(1, 5'd5, 32'hA000_0001, 1, 5'd5, 32'hB000_0002, 1, 5'd9, 32'hC000_0003);
    applyCycle(1, 5'd12, 32'hD000_0004, 0, 0, 0, 1, 5'd5, 32'hF000_0006);
    checks++; if (pendingCount !== 4'd3) begin errors++; $display("FAIL mid_count_before got %0d exp 3", pendingCount); end
    checks++; if (we2 !== 1'b1) begin errors++; $display("FAIL mid_we2_before got %b exp 1", we2); end
`ifdef REGFILE_WB_FWD_EN
    fwdReg = 5'd5;
    #1;
    checks++; if ({fwdHit, fwdData} !== {1'b1, 32'hF000_0006}) begin
      errors++; $display("FAIL mid_fwd5 got %b/%h exp 1/f0000006", fwdHit, fwdData); end
    fwdReg = 5'd0;
    #1;
    checks++; if (fwdHit !== 1'b0) begin errors++; $display("FAIL mid_fwd0 got %b exp 0", fwdHit); end
`endif
    #1;
    rst = 1'b0;
    #1;
    checks++; if ({we1, we2} !== 2'b00) begin errors++; $display("FAIL mid_we_async got %b exp 00", {we1, we2}); end
    checks++; if (pendingCount !== 4'd0) begin errors++; $display("FAIL mid_count_async got %0d exp 0", pendingCount); end
    @(negedge clk);
    checks++; if ({we1, we2} !== 2'b00) begin errors++; $display("FAIL mid_we_inreset got %b exp 00", {we1, we2}); end
    rst = 1'b1;
    modelReset();
    for (int c = 0; c < 4; c++) begin
      idleCycle();
      checks++; if ({we1, we2, pendingCount} !== 6'b0) begin
        errors++; $display("FAIL mid_after c%0d got we %b count %0d exp 00/0", c, {we1, we2}, pendingCount); end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_pair();
    test_conflict();
    test_dest0();
    test_burst();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
